// File: rtl/sram_frame_controller_pkg.sv
// Shared types and constants for the SRAM frame controller slice.
package sram_frame_controller_pkg;

  localparam int unsigned H_RES   = 640;
  localparam int unsigned V_RES   = 480;
  localparam int unsigned SRAM_AW = 20;

  typedef logic [15:0] pixel_t;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    pixel_t     data;
  } fb_entry_t;

  typedef enum logic {
    PH_R = 1'b0,
    PH_W = 1'b1
  } phase_t;

  // SRAM word address: frame select on top, then row, then column.
  function automatic logic [SRAM_AW-1:0] fb_addr(input logic frame,
                                                 input logic [8:0] y,
                                                 input logic [9:0] x);
    return {frame, y, x};
  endfunction

endpackage

// File: rtl/sram_frame_controller_if.sv
// Pixel-write handshake from the copy engine into the frame controller.
interface sram_frame_controller_if;
  import sram_frame_controller_pkg::*;

  logic [9:0] program_x;
  logic [9:0] program_y;
  pixel_t     program_data;
  logic       program_write;
  logic       program_ready;

  modport master (
    output program_x, program_y, program_data, program_write,
    input  program_ready
  );

  modport slave (
    input  program_x, program_y, program_data, program_write,
    output program_ready
  );
endinterface

// File: rtl/sram_frame_controller_program_fifo.sv
// Synchronous FIFO of pending pixel writes; head is read directly from storage.
module program_fifo
  import sram_frame_controller_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      push,
  input  fb_entry_t                 push_data,
  input  logic                      pop,
  output fb_entry_t                 head,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  fb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/sram_frame_controller.sv
// Shares one async SRAM between VGA fetches (phase R) and queued pixel writes
// (phase W), and double-buffers the frame store with swaps at frame start.
module sram_frame_controller #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned H_RES      = sram_frame_controller_pkg::H_RES,
  parameter int unsigned V_RES      = sram_frame_controller_pkg::V_RES
) (
  input  logic                                           CLK,
  input  logic                                           RESET,
  sram_frame_controller_if.slave                         prog,
  input  logic [9:0]                                     draw_x,
  input  logic [9:0]                                     draw_y,
  input  logic                                           frame_start,
  output sram_frame_controller_pkg::pixel_t              vga_pixel,
  input  logic                                           swap_req,
  output logic                                           swap_done,
  output logic                                           current_frame,
  output logic                                           overflow,
  output logic [sram_frame_controller_pkg::SRAM_AW-1:0]  SRAM_ADDR,
  inout  wire  [15:0]                                    SRAM_DQ,
  output logic                                           SRAM_WE_N,
  output logic                                           SRAM_OE_N,
  output logic                                           SRAM_CE_N,
  output logic                                           SRAM_UB_N,
  output logic                                           SRAM_LB_N
);
  import sram_frame_controller_pkg::*;

  phase_t                         phase;
  phase_t                         phase_nxt;
  fb_entry_t                      head;
  fb_entry_t                      push_data;
  logic [$clog2(FIFO_DEPTH):0]    count;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic                           in_range;
  logic                           push;
  logic                           pop;
  logic                           swap_pend;
  logic                           do_swap;
  logic                           dq_oe;

  assign prog.program_ready = !fifo_full;
  assign in_range  = (32'(prog.program_x) < H_RES) && (32'(prog.program_y) < V_RES);
  assign push      = prog.program_write && prog.program_ready && in_range;
  assign pop       = (phase == PH_W) && !fifo_empty;
  assign push_data = '{x: prog.program_x, y: prog.program_y[8:0], data: prog.program_data};
  // Registered count only: a push landing in the same cycle does not block the swap.
  assign do_swap   = frame_start && swap_pend && (count == '0);

  program_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Phase register: R and W alternate every cycle, starting with R out of reset.
  always_ff @(posedge CLK) begin
    if (!RESET) phase <= PH_R;
    else        phase <= phase_nxt;
  end

  // Next phase and SRAM strobe decode; everything idles while reset is held.
  always_comb begin
    phase_nxt = (phase == PH_R) ? PH_W : PH_R;
    SRAM_ADDR = fb_addr(current_frame, draw_y[8:0], draw_x);
    SRAM_CE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_oe     = 1'b0;
    if (RESET) begin
      SRAM_CE_N = 1'b0;
      SRAM_UB_N = 1'b0;
      SRAM_LB_N = 1'b0;
      if (phase == PH_R) begin
        SRAM_OE_N = 1'b0;
      end else if (!fifo_empty) begin
        SRAM_ADDR = fb_addr(~current_frame, head.y, head.x);
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
      end
    end
  end

  assign SRAM_DQ = dq_oe ? head.data : 'z;

  // Frame select, swap handshake, overflow flag and fetched pixel capture.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      current_frame <= 1'b0;
      swap_pend     <= 1'b0;
      swap_done     <= 1'b0;
      overflow      <= 1'b0;
      vga_pixel     <= '0;
    end else begin
      swap_done <= do_swap;
      if (do_swap) begin
        current_frame <= ~current_frame;
        swap_pend     <= 1'b0;
      end else if (swap_req) begin
        swap_pend <= 1'b1;
      end
      if (prog.program_write && !prog.program_ready) overflow <= 1'b1;
      if (phase == PH_R) vga_pixel <= SRAM_DQ;
    end
  end

endmodule

// File: tb/tb_sram_frame_controller.sv
// Bench for sram_frame_controller: behavioural SRAM plus a queue-based reference
// of the write path, swap handshake and pixel fetch, checked every cycle.
`timescale 1ns/1ps
module tb_sram_frame_controller;
  import sram_frame_controller_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [9:0]  draw_x, draw_y;
  logic        frame_start, swap_req;
  pixel_t      vga_pixel;
  logic        swap_done, current_frame, overflow;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  always #5 CLK = ~CLK;

  sram_frame_controller_if pif ();

  sram_frame_controller #(.FIFO_DEPTH(DEPTH), .H_RES(640), .V_RES(480)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .prog          (pif),
    .draw_x        (draw_x),
    .draw_y        (draw_y),
    .frame_start   (frame_start),
    .vga_pixel     (vga_pixel),
    .swap_req      (swap_req),
    .swap_done     (swap_done),
    .current_frame (current_frame),
    .overflow      (overflow),
    .SRAM_ADDR     (sram_addr),
    .SRAM_DQ       (sram_dq),
    .SRAM_WE_N     (we_n),
    .SRAM_OE_N     (oe_n),
    .SRAM_CE_N     (ce_n),
    .SRAM_UB_N     (ub_n),
    .SRAM_LB_N     (lb_n)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural async SRAM ----------------
  pixel_t      sram_mem [int unsigned];
  pixel_t      rd_word = '0;
  int unsigned wr_cnt = 0;

  assign sram_dq = (!ce_n && !oe_n && we_n) ? rd_word : 'z;

  always @(negedge CLK) begin
    rd_word = sram_mem.exists(32'(sram_addr)) ? sram_mem[32'(sram_addr)] : 16'h0000;
  end

  always @(posedge CLK) begin
    if (!ce_n && !we_n) begin
      sram_mem[32'(sram_addr)] = sram_dq;
      wr_cnt++;
    end
  end

  // ---------------- reference model ----------------
  fb_entry_t   m_q [$];
  pixel_t      m_mem [int unsigned];
  logic        m_w = 1'b0;
  logic        m_cf = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_sd = 1'b0;
  pixel_t      m_vga = '0;

  always @(posedge CLK) begin
    int unsigned sz0;
    logic        rdy;
    logic        acc;
    fb_entry_t   e;
    int unsigned a;
    if (!RESET) begin
      m_q.delete();
      m_w = 1'b0; m_cf = 1'b0; m_pend = 1'b0; m_ovf = 1'b0; m_sd = 1'b0; m_vga = '0;
    end else begin
      sz0 = m_q.size();
      rdy = (sz0 < DEPTH);
      acc = pif.program_write && rdy && (32'(pif.program_x) < 640) && (32'(pif.program_y) < 480);
      if (pif.program_write && !rdy) m_ovf = 1'b1;
      if (!m_w) begin
        a = {12'b0, m_cf, draw_y[8:0], draw_x};
        m_vga = m_mem.exists(a) ? m_mem[a] : 16'h0000;
      end else if (sz0 > 0) begin
        e = m_q.pop_front();
        m_mem[{12'b0, ~m_cf, e.y, e.x}] = e.data;
      end
      m_sd = 1'b0;
      if (frame_start && m_pend && sz0 == 0) begin
        m_cf = ~m_cf; m_sd = 1'b1; m_pend = 1'b0;
      end else if (swap_req) begin
        m_pend = 1'b1;
      end
      if (acc) begin
        e.x = pif.program_x; e.y = pif.program_y[8:0]; e.data = pif.program_data;
        m_q.push_back(e);
      end
      m_w = ~m_w;
    end
  end

  // Per-cycle comparison of all outputs against the model, away from the edge.
  always @(negedge CLK) begin
    if (!RESET) begin
      check_eq("rst_ce_n", 32'(ce_n), 32'd1);
      check_eq("rst_we_n", 32'(we_n), 32'd1);
      check_eq("rst_oe_n", 32'(oe_n), 32'd1);
    end else begin
      check_eq("ready", 32'(pif.program_ready), 32'(m_q.size() < DEPTH));
      check_eq("overflow", 32'(overflow), 32'(m_ovf));
      check_eq("frame", 32'(current_frame), 32'(m_cf));
      check_eq("swap_done", 32'(swap_done), 32'(m_sd));
      check_eq("vga", 32'(vga_pixel), 32'(m_vga));
      check_eq("ce_n", 32'({ce_n, ub_n, lb_n}), 32'd0);
      if (!m_w) begin
        check_eq("r_oe_n", 32'(oe_n), 32'd0);
        check_eq("r_we_n", 32'(we_n), 32'd1);
        check_eq("r_addr", 32'(sram_addr), 32'({m_cf, draw_y[8:0], draw_x}));
      end else if (m_q.size() > 0) begin
        check_eq("w_we_n", 32'(we_n), 32'd0);
        check_eq("w_oe_n", 32'(oe_n), 32'd1);
        check_eq("w_addr", 32'(sram_addr), 32'({~m_cf, m_q[0].y, m_q[0].x}));
        check_eq("w_dq", 32'(sram_dq), 32'(m_q[0].data));
      end else begin
        check_eq("idle_we_n", 32'(we_n), 32'd1);
        check_eq("idle_oe_n", 32'(oe_n), 32'd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic drive_px(input int unsigned x, input int unsigned y, input pixel_t d);
    pif.program_write = 1'b1;
    pif.program_x     = 10'(x);
    pif.program_y     = 10'(y);
    pif.program_data  = d;
  endtask

  task automatic wait_write(input string tag, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge CLK);
      if (!we_n) seen = 1'b1;
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic        seen;
    int unsigned w0;
    logic        burst;
    pif.program_write = 1'b0;
    pif.program_x = '0; pif.program_y = '0; pif.program_data = '0;
    draw_x = '0; draw_y = '0; frame_start = 1'b0; swap_req = 1'b0;
    sram_mem[32'h0] = 16'h1234;            m_mem[32'h0] = 16'h1234;
    sram_mem[32'h0140A] = 16'h5555;        m_mem[32'h0140A] = 16'h5555;

    // Reset, then fetch (0,0) from frame 0.
    repeat (3) tick();
    RESET = 1'b1;
    tick();
    @(negedge CLK);
    check_eq("first_fetch", 32'(vga_pixel), 32'h1234);
    repeat (3) tick();
    check_eq("frame_after_rst", 32'(current_frame), 32'd0);

    // Single write lands in the draw frame (frame 1).
    drive_px(10, 5, 16'hBEEF);
    tick();
    pif.program_write = 1'b0;
    wait_write("beef", seen);
    if (seen) begin
      check_eq("beef_addr", 32'(sram_addr), 32'h8140A);
      check_eq("beef_dq", 32'(sram_dq), 32'hBEEF);
    end
    tick();
    draw_x = 10'd10; draw_y = 10'd5;
    repeat (2) tick();
    @(negedge CLK);
    check_eq("old_frame_read", 32'(vga_pixel), 32'h5555);
    tick();

    // Out-of-range writes are silently discarded.
    w0 = wr_cnt;
    drive_px(640, 0, 16'h1111); tick();
    drive_px(0, 480, 16'h2222); tick();
    pif.program_write = 1'b0;
    repeat (6) tick();
    check_eq("oor_writes", wr_cnt - w0, 32'd0);
    check_eq("oor_ovf", 32'(overflow), 32'd0);

    // Swap request with writes queued is deferred until the FIFO drains.
    for (int i = 1; i <= 3; i++) begin
      drive_px(32'(i), 7, 16'(16'hC000 + i)); tick();
    end
    pif.program_write = 1'b0;
    swap_req = 1'b1; tick();
    swap_req = 1'b0; frame_start = 1'b1; tick();
    frame_start = 1'b0;
    check_eq("swap_deferred", 32'(current_frame), 32'd0);
    check_eq("swap_deferred_pulse", 32'(swap_done), 32'd0);
    repeat (10) tick();
    frame_start = 1'b1; tick();
    frame_start = 1'b0;
    check_eq("swap_frame", 32'(current_frame), 32'd1);
    check_eq("swap_pulse", 32'(swap_done), 32'd1);
    tick();
    check_eq("swap_pulse_end", 32'(swap_done), 32'd0);
    drive_px(4, 4, 16'hA5A5); tick();
    pif.program_write = 1'b0;
    wait_write("after_swap", seen);
    if (seen) check_eq("after_swap_bit19", 32'(sram_addr[19]), 32'd0);
    tick();

    // Back-to-back burst until the FIFO fills and overflows.
    for (int i = 0; i < 20; i++) begin
      drive_px(32'(100 + i), 20, 16'(i)); tick();
    end
    pif.program_write = 1'b0;
    check_eq("burst_ovf", 32'(overflow), 32'd1);
    repeat (20) tick();

    // Reset in the middle of a write slot with entries queued.
    for (int i = 0; i < 5; i++) begin
      drive_px(32'(200 + i), 30, 16'(16'hD000 + i)); tick();
    end
    pif.program_write = 1'b0;
    wait_write("pre_rst", seen);
    #1 RESET = 1'b0;
    #1 check_eq("rst_abort_we_n", 32'(we_n), 32'd1);
    tick();
    RESET = 1'b1;
    @(negedge CLK);
    check_eq("rst_frame", 32'(current_frame), 32'd0);
    check_eq("rst_ready", 32'(pif.program_ready), 32'd1);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    w0 = wr_cnt;
    repeat (6) tick();
    check_eq("rst_flushed", wr_cnt - w0, 32'd0);

    // Randomized traffic with bursty writes, swaps and fetches.
    burst = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 64 == 0) burst = ($urandom_range(0, 3) == 0);
      frame_start = ($urandom_range(0, 39) == 0);
      swap_req    = !frame_start && ($urandom_range(0, 9) == 0);
      pif.program_write = !frame_start &&
                          (burst ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0));
      pif.program_x = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(630, 700))
                                                  : 10'($urandom_range(0, 15));
      pif.program_y = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(470, 520))
                                                  : 10'($urandom_range(0, 15));
      pif.program_data = 16'($urandom);
      draw_x = 10'($urandom_range(0, 15));
      draw_y = 10'($urandom_range(0, 15));
      tick();
    end
    pif.program_write = 1'b0; frame_start = 1'b0; swap_req = 1'b0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
